// File: rtl/conv_3ch_seq_pkg.sv
// Shared constants and state encoding for the 3-channel convolution sequencer.
package conv_3ch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  localparam int IF_SIZE_DEF   = 12;
  localparam int K_SIZE_DEF    = 5;
  localparam int DRAIN_MAX_DEF = 64;

  function automatic int of_size(input int if_size, input int k_size);
    return if_size - k_size + 1;
  endfunction

  localparam int OF        = of_size(IF_SIZE_DEF, K_SIZE_DEF);
  localparam int PIX_TOTAL = IF_SIZE_DEF * IF_SIZE_DEF;
  localparam int RES_TOTAL = OF * OF;

endpackage

// File: rtl/conv_3ch_seq.sv
// Sequencer: clear engine, stream one fmap from the input BRAM, drain the
// engine pipeline and write results linearly, honouring output backpressure.
module conv_3ch_seq
  import conv_3ch_seq_pkg::*;
#(
  parameter int IF_SIZE_CONV = IF_SIZE_DEF,
  parameter int K_SIZE       = K_SIZE_DEF,
  parameter int RD_ADDR_BW   = 8,
  parameter int WR_ADDR_BW   = 6,
  parameter int DRAIN_MAX    = DRAIN_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_out_full,
  input  logic                  i_conv_valid,
  output logic                  o_rd_en,
  output logic [RD_ADDR_BW-1:0] o_rd_addr,
  output logic                  o_conv_ce,
  output logic                  o_conv_clr,
  output logic                  o_wr_en,
  output logic [WR_ADDR_BW-1:0] o_wr_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int N_PIX = IF_SIZE_CONV * IF_SIZE_CONV;
  localparam int N_RES = of_size(IF_SIZE_CONV, K_SIZE) * of_size(IF_SIZE_CONV, K_SIZE);
  localparam int RES_W = WR_ADDR_BW + 1;  // one extra bit so the count can sit at N_RES
  localparam int DRN_W = $clog2(DRAIN_MAX + 1);

  seq_state_e state, state_nxt;

  logic [RD_ADDR_BW-1:0] pix_cnt;
  logic [RES_W-1:0]      res_cnt;
  logic [DRN_W-1:0]      drn_cnt;
  logic [1:0]            ce_pipe;   // [0] = engine enable, [1] = enable one cycle older
  logic                  ce_d;
  logic                  err_q;
  logic                  pix_last, res_last, res_full, drn_last;
  logic                  wr_done, timeout;

  assign pix_last = (pix_cnt == RD_ADDR_BW'(N_PIX - 1));
  assign res_last = (res_cnt == RES_W'(N_RES - 1));
  assign res_full = (res_cnt == RES_W'(N_RES));
  assign drn_last = (drn_cnt == DRN_W'(DRAIN_MAX - 1));

  // A result is only fresh when the engine advanced on the previous edge.
  assign o_wr_en = i_conv_valid & ce_pipe[1] & ~res_full
                 & ((state == S_STREAM) | (state == S_DRAIN));

  // Completing the last write wins over a coincident drain timeout.
  assign wr_done = res_full | (o_wr_en & res_last);
  assign timeout = (state == S_DRAIN) & drn_last & ~wr_done;

  assign o_rd_addr = pix_cnt;
  assign o_wr_addr = res_cnt[WR_ADDR_BW-1:0];
  assign o_conv_ce = ce_pipe[0];
  assign o_err     = err_q;

  always_comb begin
    state_nxt  = state;
    o_rd_en    = 1'b0;
    o_conv_clr = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    ce_d       = 1'b0;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        o_conv_clr = 1'b1;
        o_busy     = 1'b1;
        state_nxt  = S_STREAM;
      end
      S_STREAM: begin
        o_busy  = 1'b1;
        o_rd_en = ~i_out_full;
        ce_d    = ~i_out_full;
        if (~i_out_full && pix_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        ce_d   = ~i_out_full;
        if (wr_done || drn_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pix_cnt <= '0;
      res_cnt <= '0;
      drn_cnt <= '0;
      ce_pipe <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ce_pipe <= {ce_pipe[0], ce_d};
      if (state == S_IDLE && i_start) err_q <= 1'b0;
      if (timeout) err_q <= 1'b1;
      if (state == S_CLEAR) begin
        pix_cnt <= '0;
        res_cnt <= '0;
        drn_cnt <= '0;
      end else begin
        if (o_rd_en && !pix_last) pix_cnt <= pix_cnt + 1'b1;
        if (o_wr_en) res_cnt <= res_cnt + 1'b1;
        if (state == S_DRAIN && !drn_last) drn_cnt <= drn_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_3ch_seq.sv
// Directed/randomized bench for conv_3ch_seq with a latency-programmable engine model.
module tb_conv_3ch_seq;

  localparam int IFS  = 12;
  localparam int K    = 5;
  localparam int OFS  = IFS - K + 1;
  localparam int NPIX = IFS * IFS;
  localparam int NRES = OFS * OFS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_out_full = 1'b0;
  logic       i_conv_valid = 1'b0;
  logic       o_rd_en, o_conv_ce, o_conv_clr, o_wr_en, o_busy, o_done, o_err;
  logic [7:0] o_rd_addr;
  logic [5:0] o_wr_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_3ch_seq dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_out_full(i_out_full),
    .i_conv_valid(i_conv_valid), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_conv_ce(o_conv_ce), .o_conv_clr(o_conv_clr), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  // Engine model: each enabled edge ingests one pixel and presents the result
  // of the pixel ingested `lat` enables earlier; only full-window pixels produce.
  int ce_n, emitted, lat, limit;
  bit extra;

  function automatic bit produces(input int p);
    return (p >= 0) && (p < NPIX) && ((p / IFS) >= K - 1) && ((p % IFS) >= K - 1);
  endfunction

  always @(posedge clk) begin
    if (rst || o_conv_clr) begin
      ce_n <= 0; emitted <= 0; i_conv_valid <= 1'b0;
    end else if (o_conv_ce) begin
      ce_n <= ce_n + 1;
      if (produces(ce_n - lat) && emitted < limit) begin
        i_conv_valid <= 1'b1;
        emitted      <= emitted + 1;
      end else begin
        i_conv_valid <= extra && (emitted >= limit);
      end
    end
  end

  int issued, writes, dones, clrs, last_wr, done_err;
  bit prev_rd_en, prev_ce, prev_full, prev_busy, prev_rst;
  int prev_issued;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs at the falling edge against the
  // frame rules, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (o_conv_clr) begin issued = 0; writes = 0; clrs++; end
    chk("rd_en", int'(o_rd_en),
        int'(o_busy && !o_conv_clr && issued < NPIX && !i_out_full));
    if (o_rd_en) chk("rd_addr", int'(o_rd_addr), issued);
    chk("conv_ce", int'(o_conv_ce),
        int'(!prev_rst && prev_busy && ((prev_issued < NPIX) ? prev_rd_en : !prev_full)));
    chk("wr_en", int'(o_wr_en), int'(i_conv_valid && prev_ce && o_busy && writes < NRES));
    if (o_wr_en) chk("wr_addr", int'(o_wr_addr), writes);
    if (o_done) begin
      dones++;
      done_err = int'(o_err);
      chk("done_busy", int'(o_busy), 0);
    end
    prev_rd_en  = o_rd_en;
    prev_ce     = o_conv_ce;
    prev_full   = i_out_full;
    prev_busy   = o_busy;
    prev_rst    = rst;
    prev_issued = issued;
    if (o_rd_en) issued++;
    if (o_wr_en) begin last_wr = int'(o_wr_addr); writes++; end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(o_rd_en), 0);
    chk({tag, "_rd_addr"}, int'(o_rd_addr), 0);
    chk({tag, "_ce"}, int'(o_conv_ce), 0);
    chk({tag, "_clr"}, int'(o_conv_clr), 0);
    chk({tag, "_wr_en"}, int'(o_wr_en), 0);
    chk({tag, "_wr_addr"}, int'(o_wr_addr), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_err"}, int'(o_err), 0);
  endtask

  // bp_mode: 0 none, 1 five stalls at pixel 50 and three in drain, 2 random in stream
  task automatic run_frame(input string name, input int l, input int lim, input bit ext,
                           input int bp_mode, input bit spur, input int exp_err,
                           input int exp_wr);
    int cyc = 0, stall = 0, dcyc = 0;
    bit s50 = 0, sd = 0, sp1 = 0, sp2 = 0;
    lat = l; limit = lim; extra = ext;
    issued = 0; writes = 0; dones = 0; clrs = 0; last_wr = -1; done_err = -1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk({name, "_err_cleared"}, int'(o_err), 0);
    while (dones == 0 && cyc < 1000) begin
      i_out_full = 1'b0;
      i_start    = 1'b0;
      if (issued >= NPIX) dcyc++;
      if (bp_mode == 1) begin
        if (stall > 0) begin
          i_out_full = 1'b1; stall--;
        end else if (!s50 && issued == 50) begin
          s50 = 1; stall = 4; i_out_full = 1'b1;
        end else if (!sd && dcyc == 4) begin
          sd = 1; stall = 2; i_out_full = 1'b1;
        end
      end else if (bp_mode == 2 && issued < NPIX) begin
        i_out_full = ($urandom_range(0, 3) == 0);
      end
      if (spur && !sp1 && issued == 10) begin sp1 = 1; i_start = 1'b1; end
      if (spur && !sp2 && dcyc == 6) begin sp2 = 1; i_start = 1'b1; end
      tick();
      cyc++;
    end
    i_out_full = 1'b0;
    i_start    = 1'b0;
    chk({name, "_done_seen"}, dones, 1);
    chk({name, "_done_err"}, done_err, exp_err);
    repeat (3) tick();
    chk({name, "_single_done"}, dones, 1);
    chk({name, "_single_clr"}, clrs, 1);
    chk({name, "_pixels"}, issued, NPIX);
    chk({name, "_writes"}, writes, exp_wr);
    chk({name, "_last_wr"}, last_wr, exp_wr - 1);
    chk({name, "_err_sticky"}, int'(o_err), exp_err);
  endtask

  initial begin
    int cyc;
    lat = 0; limit = NRES; extra = 0;
    issued = 0; writes = 0; dones = 0; clrs = 0;
    prev_rd_en = 0; prev_ce = 0; prev_full = 0; prev_busy = 0; prev_rst = 0; prev_issued = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    run_frame("basic",      $urandom_range(0, 10), NRES, 0, 0, 0, 0, NRES);
    run_frame("backpress",  $urandom_range(0, 10), NRES, 0, 1, 0, 0, NRES);
    run_frame("timeout",    $urandom_range(0, 10), 60,   0, 0, 0, 1, 60);
    run_frame("busy_start", 20,                    NRES, 0, 0, 1, 0, NRES);
    run_frame("coincide",   62,                    NRES, 1, 0, 0, 0, NRES);
    run_frame("late",       63,                    NRES, 0, 0, 0, 1, NRES - 1);
    run_frame("random_bp",  $urandom_range(0, 15), NRES, 0, 2, 0, 0, NRES);

    // Reset in the middle of streaming, then a clean restart.
    lat = 3; limit = NRES; extra = 0;
    issued = 0; writes = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cyc = 0;
    while (issued < 77 && cyc < 500) begin tick(); cyc++; end
    chk("mid_reach_77", issued, 77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_reset");
    tick();
    run_frame("after_rst", $urandom_range(0, 10), NRES, 0, 0, 0, 0, NRES);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
